// File: rtl/fetch_prefetch_unit_if.sv
// Bundle between the prefetching fetch stage, the instruction memory port,
// the condition unit (redirects) and the decode stage.
// master = the fetch unit, slave = everything around it.
interface fetch_prefetch_unit_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Instruction memory request channel
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;

    // Instruction memory response channel (in order, always accepted)
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    // Taken jump from the condition unit
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    // Decode-side handshake
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [CW-1:0]   if_count;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output if_valid, if_instr, if_pc, if_count,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  if_valid, if_instr, if_pc, if_count,
        output if_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Prefetching instruction fetch stage.
// Issues word-addressed fetches on a ready/valid memory port, buffers the
// in-order responses together with their PC in a DEPTH-entry queue and hands
// them to decode. A redirect flushes the queue and silently discards every
// response that was already in flight when the jump was taken.
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_STEP  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_prefetch_unit_if.master bus
);
    localparam int unsigned     AW      = $clog2(DEPTH);
    localparam int unsigned     CW      = AW + 1;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP_W  = XLEN'(PC_STEP);

    // Architectural state
    logic [XLEN-1:0] fetch_pc_q,    fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q,      rsp_pc_d;
    logic [AW-1:0]   head_q,        head_d;
    logic [AW-1:0]   tail_q,        tail_d;
    logic [CW-1:0]   count_q,       count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q,    drop_cnt_d;

    // Handshake qualifiers
    logic [CW:0] inflight;
    logic        credit_ok;
    logic        req_valid;
    logic        req_fire;
    logic        rsp_drop;
    logic        enq;
    logic        deq;

    // Queue storage views
    logic [XLEN-1:0] slot_instr [DEPTH];
    logic [XLEN-1:0] slot_pc    [DEPTH];

    // Queued entries plus requests in flight must never exceed the queue
    // size, so every response that is kept is guaranteed a free slot. A
    // dequeue happening in the same cycle is deliberately not credited.
    assign inflight  = {1'b0, count_q} + {1'b0, outstanding_q};
    assign credit_ok = inflight < DEPTH_W;

    // Requests are masked while in reset and during the redirect cycle.
    assign req_valid = rst && !bus.redirect_valid && credit_ok;
    assign req_fire  = req_valid && bus.imem_req_ready;

    // A response is either swallowed (stale, fetched before a redirect) or
    // written into the queue. A redirect in the same cycle overrides both
    // enqueue and dequeue.
    assign rsp_drop = bus.imem_rsp_valid && (drop_cnt_q != '0);
    assign enq      = bus.imem_rsp_valid && (drop_cnt_q == '0) && !bus.redirect_valid;
    assign deq      = (count_q != '0) && bus.if_ready && !bus.redirect_valid;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = fetch_pc_q;
    assign bus.if_valid       = (count_q != '0);
    assign bus.if_instr       = slot_instr[head_q];
    assign bus.if_pc          = slot_pc[head_q];
    assign bus.if_count       = count_q;

    // Next-state computation for PCs, queue pointers and the credit counters.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        drop_cnt_d    = drop_cnt_q;
        // Every accepted request adds one, every response (kept or dropped)
        // retires one; this holds in the redirect cycle as well.
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            rsp_pc_d   = bus.redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            // Everything still in flight after this edge belongs to the old
            // path; a response arriving right now is already discarded.
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + STEP_W;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (enq) begin
                tail_d   = tail_q + 1'b1;
                rsp_pc_d = rsp_pc_q + STEP_W;
            end
            if (deq) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Queue slots: data-only registers, validity is tracked by count/pointers.
    // The head is read combinationally so a response is visible one cycle
    // after it arrives.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [XLEN-1:0] instr_q;
            logic [XLEN-1:0] pc_q;

            // Capture the response and its PC when this slot is the tail.
            always_ff @(posedge clk) begin
                if (enq && (tail_q == AW'(gi))) begin
                    instr_q <= bus.imem_rsp_data;
                    pc_q    <= rsp_pc_q;
                end
            end

            assign slot_instr[gi] = instr_q;
            assign slot_pc[gi]    = pc_q;
        end
    endgenerate

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: an in-order instruction memory with
// programmable latency answers the fetch port; each task drives one scenario
// and checks the decode-side and request-side outputs inline.
module tb_fetch_prefetch_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_prefetch_unit_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_prefetch_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC('0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Memory model state
    int          lat      = 1;
    int          cyc      = 0;
    int          last_due = -1;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic [31:0] fire_log  [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Instruction memory: responds at +1 after negedge, samples request
    // handshakes at +4 (just before the posedge), is cleared by reset.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            if (!rst) begin
                pend_addr.delete();
                pend_due.delete();
                last_due = -1;
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end else begin
                if (bus.if_count > CW'(DEPTH)) begin
                    fails++;
                    $display("FAIL inv_count: if_count=%0d limit=%0d", bus.if_count, DEPTH);
                end
                if (int'(bus.if_count) + pend_addr.size() > DEPTH) begin
                    fails++;
                    $display("FAIL inv_credit: count+outstanding=%0d limit=%0d",
                             int'(bus.if_count) + pend_addr.size(), DEPTH);
                end
                if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_word(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    bus.imem_rsp_valid = 1'b0;
                    bus.imem_rsp_data  = '0;
                end
            end
            #3;
            if (rst && bus.imem_req_valid && bus.imem_req_ready) begin
                int due;
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                pend_addr.push_back(bus.imem_addr);
                pend_due.push_back(due);
                last_due = due;
                fire_log.push_back(bus.imem_addr);
                $display("[TB] req addr=%08h due=%0d", bus.imem_addr, due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        tests++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
        tests++; if (bus.if_valid !== 1'b0) begin fails++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); end
        tests++; if (bus.if_count !== '0) begin fails++; $display("FAIL reset_if_count: got %0d want 0", bus.if_count); end
    endtask

    task automatic test_fill();
        @(negedge clk);
        rst = 1'b1;
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.if_ready = 1'b0;
        fire_log.delete();
        #3;
        tests++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin fails++; $display("FAIL fill_first_req: valid=%b addr=%h want 1/0", bus.imem_req_valid, bus.imem_addr); end
        repeat (8) @(negedge clk);
        #3;
        tests++; if (fire_log.size() != 4) begin fails++; $display("FAIL fill_req_count: got %0d want 4", fire_log.size()); end
        for (int i = 0; i < fire_log.size() && i < 4; i++) begin
            tests++; if (fire_log[i] !== 32'(i)) begin fails++; $display("FAIL fill_req_addr%0d: got %h want %h", i, fire_log[i], i); end
        end
        tests++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL fill_credit_stop: req_valid=%b want 0", bus.imem_req_valid); end
        tests++; if (bus.if_count !== CW'(4)) begin fails++; $display("FAIL fill_count: got %0d want 4", bus.if_count); end
        tests++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin fails++; $display("FAIL fill_head_pc: valid=%b pc=%h want 1/0", bus.if_valid, bus.if_pc); end
        tests++; if (bus.if_instr !== mem_word(32'h0)) begin fails++; $display("FAIL fill_head_instr: got %h want %h", bus.if_instr, mem_word(32'h0)); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus.if_ready = 1'b1;
            #3;
            $display("[TB] deq pc=%08h instr=%08h count=%0d", bus.if_pc, bus.if_instr, bus.if_count);
            tests++; if (bus.if_valid !== 1'b1) begin fails++; $display("FAIL stream_bubble%0d: if_valid=%b want 1", k, bus.if_valid); end
            tests++; if (bus.if_pc !== exp_pc) begin fails++; $display("FAIL stream_pc%0d: got %h want %h", k, bus.if_pc, exp_pc); end
            tests++; if (bus.if_instr !== mem_word(exp_pc)) begin fails++; $display("FAIL stream_instr%0d: got %h want %h", k, bus.if_instr, mem_word(exp_pc)); end
            tests++; if (bus.if_count > CW'(4)) begin fails++; $display("FAIL stream_count%0d: got %0d want <=4", k, bus.if_count); end
            exp_pc = exp_pc + 1;
        end
    endtask

    task automatic test_redirect_drop();
        bit found;
        // Park fetch at 8 with nothing in flight.
        @(negedge clk);
        bus.if_ready = 1'b1;
        bus.imem_req_ready = 1'b0;
        lat = 3;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        repeat (8) @(negedge clk);
        #3;
        tests++; if (bus.if_valid !== 1'b0 || bus.if_count !== '0) begin fails++; $display("FAIL drop_parked: valid=%b count=%0d want 0/0", bus.if_valid, bus.if_count); end
        // Two fetches (8, 9) go out with latency 3.
        @(negedge clk);
        bus.if_ready = 1'b0;
        bus.imem_req_ready = 1'b1;
        #3;
        tests++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h8) begin fails++; $display("FAIL drop_req8: valid=%b addr=%h want 1/8", bus.imem_req_valid, bus.imem_addr); end
        @(negedge clk);
        #3;
        tests++; if (bus.imem_addr !== 32'h9) begin fails++; $display("FAIL drop_req9: addr=%h want 9", bus.imem_addr); end
        // Jump while both are still in flight.
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        #3;
        tests++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL drop_no_req_in_redirect: valid=%b want 0", bus.imem_req_valid); end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #3;
        tests++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h40) begin fails++; $display("FAIL drop_restart_req: valid=%b addr=%h want 1/40", bus.imem_req_valid, bus.imem_addr); end
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #3;
            if (bus.if_valid) begin found = 1'b1; break; end
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL drop_timeout: if_valid=0 want 1 within 20 cycles");
        end else if (bus.if_pc !== 32'h40 || bus.if_instr !== mem_word(32'h40)) begin
            fails++; $display("FAIL drop_first_head: pc=%h instr=%h want 40/%h", bus.if_pc, bus.if_instr, mem_word(32'h40));
        end
    endtask

    task automatic test_redirect_collide();
        bit found;
        int exp_drop;
        @(negedge clk);
        lat = 1;
        bus.if_ready = 1'b1;
        bus.imem_req_ready = 1'b1;
        repeat (8) @(negedge clk);
        found = 1'b0;
        exp_drop = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #2;
            if (bus.imem_rsp_valid && bus.if_valid) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc = 32'h100;
                exp_drop = pend_addr.size();
                found = 1'b1;
                break;
            end
        end
        tests++; if (!found) begin fails++; $display("FAIL collide_setup: no cycle with rsp_valid and if_valid within 10 cycles"); end
        #1;
        tests++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL collide_no_req: valid=%b want 0", bus.imem_req_valid); end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #3;
        tests++; if (bus.if_valid !== 1'b0 || bus.if_count !== '0) begin fails++; $display("FAIL collide_flush: valid=%b count=%0d want 0/0", bus.if_valid, bus.if_count); end
        tests++; if (dut.drop_cnt_q !== CW'(exp_drop)) begin fails++; $display("FAIL collide_drop_cnt: got %0d want %0d", dut.drop_cnt_q, exp_drop); end
        tests++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h100) begin fails++; $display("FAIL collide_restart: valid=%b addr=%h want 1/100", bus.imem_req_valid, bus.imem_addr); end
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #3;
            if (bus.if_valid) begin found = 1'b1; break; end
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL collide_timeout: if_valid=0 want 1 within 20 cycles");
        end else if (bus.if_pc !== 32'h100 || bus.if_instr !== mem_word(32'h100)) begin
            fails++; $display("FAIL collide_first_head: pc=%h instr=%h want 100/%h", bus.if_pc, bus.if_instr, mem_word(32'h100));
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_addr;
        int n;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        bus.if_ready = 1'b1;
        repeat (3) @(negedge clk);
        exp_addr = fire_log[$] + 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #3;
            tests++; if (bus.imem_req_valid !== 1'b1) begin fails++; $display("FAIL stall_valid%0d: got %b want 1", k, bus.imem_req_valid); end
            tests++; if (bus.imem_addr !== exp_addr) begin fails++; $display("FAIL stall_addr%0d: got %h want %h", k, bus.imem_addr, exp_addr); end
            tests++; if (dut.outstanding_q !== '0) begin fails++; $display("FAIL stall_outstanding%0d: got %0d want 0", k, dut.outstanding_q); end
        end
        n = fire_log.size();
        @(negedge clk);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (fire_log.size() != n + 1 || fire_log[$] !== exp_addr) begin
            fails++; $display("FAIL stall_release: fires=%0d last=%h want %0d/%h", fire_log.size() - n, fire_log[$], 1, exp_addr);
        end
    endtask

    task automatic test_async_reset();
        bit hit;
        bit found;
        @(negedge clk);
        lat = 1;
        bus.imem_req_ready = 1'b1;
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h200;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.if_count == CW'(3) && pend_addr.size() == 1) begin hit = 1'b1; break; end
        end
        tests++; if (!hit) begin fails++; $display("FAIL areset_setup: never saw 3 queued with 1 outstanding"); end
        rst = 1'b0;
        #2;
        tests++; if (bus.if_valid !== 1'b0) begin fails++; $display("FAIL areset_if_valid: got %b want 0", bus.if_valid); end
        tests++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL areset_req_valid: got %b want 0", bus.imem_req_valid); end
        tests++; if (bus.if_count !== '0) begin fails++; $display("FAIL areset_if_count: got %0d want 0", bus.if_count); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        fire_log.delete();
        #3;
        tests++; if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin fails++; $display("FAIL areset_restart: valid=%b addr=%h want 1/0", bus.imem_req_valid, bus.imem_addr); end
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #3;
            if (bus.if_valid) begin found = 1'b1; break; end
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL areset_timeout: if_valid=0 want 1 within 20 cycles");
        end else if (bus.if_pc !== 32'h0 || bus.if_instr !== mem_word(32'h0)) begin
            fails++; $display("FAIL areset_first_head: pc=%h instr=%h want 0/%h", bus.if_pc, bus.if_instr, mem_word(32'h0));
        end
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b0;
        test_reset();
        test_fill();
        test_stream();
        test_redirect_drop();
        test_redirect_collide();
        test_stall();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised successor to the processor's single-register fetch stage (PC register, PC+1 adder, fetch pipeline register flushed on jump).
- Issues word-addressed instruction fetches to a ready/valid instruction-memory port that returns responses in order with arbitrary latency (≥1 cycle).
- Buffers returned instructions with their PC in a DEPTH-entry prefetch queue and presents them to decode through a valid/ready handshake.
- A redirect (taken jump from the condition unit) flushes the queue and discards responses still in flight.

Parameters:
XLEN, 32, width of PC, address and instruction.
DEPTH, 4, prefetch queue entries; power of two, ≥2.
PC_STEP, 1, PC increment per instruction (word addressing).
RESET_PC, 0, fetch address after reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_addr  out  XLEN  fetch address (current fetch PC).
imem_rsp_valid  in  1  response valid; in order; always accepted.
imem_rsp_data  in  XLEN  returned instruction.
redirect_valid  in  1  flush and restart fetch.
redirect_pc  in  XLEN  restart address.
if_valid  out  1  queue head valid.
if_ready  in  1  decode consumes head.
if_instr  out  XLEN  head instruction.
if_pc  out  XLEN  PC of head instruction.
if_count  out  $clog2(DEPTH)+1  queue occupancy.

Behaviour:
- State: fetch_pc, rsp_pc, queue (instr, pc), count, outstanding (0..DEPTH), drop_cnt (0..DEPTH).
- Reset (rst=0, async): fetch_pc=rsp_pc=RESET_PC; count=outstanding=drop_cnt=0; queue pointers 0.
- Outputs during reset: imem_req_valid=0, if_valid=0, if_count=0.
- Request issue:
  - imem_req_valid = !redirect_valid && (count+outstanding < DEPTH). This is combinational.
  - imem_addr = fetch_pc.
  - On fire (valid && ready): fetch_pc += PC_STEP; outstanding++.
  - fetch_pc is held while ready=0.
- Credit rule: count+outstanding never exceeds DEPTH, so every kept response has a free queue slot. A same-cycle dequeue is not credited.
- Response handling (imem_rsp_valid=1, always accepted):
  - outstanding--.
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Else: enqueue {imem_rsp_data, rsp_pc}; rsp_pc += PC_STEP.
- Latency: a response arriving in cycle N is visible at if_valid/if_instr in cycle N+1.
- Dequeue: if_valid = (count!=0). On if_valid && if_ready the head pops. Enqueue and dequeue in the same cycle leave count unchanged.
- Redirect (registered at the clock edge):
  - Queue flushed (count=0, pointers reset); fetch_pc=rsp_pc=redirect_pc.
  - drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0); any response in the redirect cycle is discarded.
  - No request issues in the redirect cycle. The first request to redirect_pc is offered the following cycle.
  - Redirect overrides a same-cycle dequeue or enqueue. A dequeue handshake in that cycle is ignored by the core; decode is flushed by the same jump.
  - Back-to-back redirects: each recomputes drop_cnt from current outstanding; last one wins.
- Wrap-around: fetch_pc, rsp_pc and queue pointers wrap modulo 2^XLEN / DEPTH with no error.
- Invariants (assert in bench): count ≤ DEPTH; outstanding ≤ DEPTH; drop_cnt ≤ outstanding; no enqueue when full; imem_rsp_valid never seen while outstanding=0.

Test Plan:
1. Reset release, imem_req_ready=1, latency 1, if_ready=0 → requests to addr 0,1,2,3, then imem_req_valid=0 with if_count=4; head if_pc=0, if_instr=mem[0].
2. Then if_ready=1 continuously → if_pc sequence 0,1,2,… one per cycle with no bubbles after refill; if_count oscillates ≤4.
3. Latency 3, two requests outstanding (addr 8, 9), redirect_pc=0x40 → both late responses dropped. First if_valid shows if_pc=0x40, and no instruction from 8/9 ever appears.
4. Redirect in the same cycle as imem_rsp_valid and as a dequeue handshake → queue empty next cycle; drop_cnt = outstanding−1; imem_addr=redirect_pc one cycle later.
5. imem_req_ready=0 for 5 cycles → imem_addr held at same value, imem_req_valid stays 1, outstanding unchanged.
6. Assert rst=0 mid-stream with 3 queued and 1 outstanding → outputs immediately if_valid=0, imem_req_valid=0, if_count=0. After release, fetch restarts at RESET_PC, and the stale response is not enqueued because the bench memory is also reset.
